// File: rtl/status_reg.sv
// CPU condition-flag register {N,Z,C,V}: ALU/bus updates, condition-code evaluation,
// tri-state bus read and a small save stack for interrupt entry/return.
module status_reg #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  alu_status,
    input  logic        load,
    input  logic        we,
    input  logic [31:0] data_in,
    input  logic        oe,
    output logic [31:0] data_out,
    input  logic        push,
    input  logic        pop,
    input  logic [3:0]  cond,
    output logic        cond_true,
    output logic        carry,
    output logic        stack_err,
    output logic [3:0]  flags
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [3:0]     flags_reg, flags_next;
    logic [SPW-1:0] sp_reg, sp_next;
    logic           err_reg, err_next;
    logic [3:0]     stack_mem [DEPTH];

    logic           both_req;
    logic           is_full;
    logic           is_empty;
    logic           push_ok;
    logic           pop_ok;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;

    assign both_req = push & pop;
    assign is_full  = (sp_reg == SP_FULL);
    assign is_empty = (sp_reg == '0);
    assign push_ok  = push & ~pop & ~is_full;
    assign pop_ok   = pop & ~push & ~is_empty;
    assign top_idx  = IW'(sp_reg - 1'b1);
    assign wr_idx   = sp_reg[IW-1:0];

    // Simultaneous push and pop cancel out entirely: stack, flags and error untouched.
    always_comb begin
        flags_next = flags_reg;
        sp_next    = sp_reg;
        err_next   = err_reg;
        if (pop_ok) begin
            flags_next = stack_mem[top_idx];
            sp_next    = sp_reg - 1'b1;
        end else if (!both_req) begin
            if (we) begin
                flags_next = data_in[3:0];
            end else if (load) begin
                flags_next = alu_status;
            end
        end
        if (push_ok) begin
            sp_next = sp_reg + 1'b1;
        end
        if (!both_req && ((push && is_full) || (pop && is_empty))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 4'b0000;
            sp_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            sp_reg    <= sp_next;
            err_reg   <= err_next;
        end
    end

    // Push always stacks the pre-edge flags, even when a load lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= 4'b0000;
            end
        end else if (push_ok) begin
            stack_mem[wr_idx] <= flags_reg;
        end
    end

    logic n_flag, z_flag, c_flag, v_flag;
    assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

    // C=1 means "no borrow", so unsigned lower-than is !C.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = 1'b1;
            4'd1:  cond_true = z_flag;
            4'd2:  cond_true = ~z_flag;
            4'd3:  cond_true = ~c_flag;
            4'd4:  cond_true = c_flag & ~z_flag;
            4'd5:  cond_true = ~c_flag | z_flag;
            4'd6:  cond_true = c_flag;
            4'd7:  cond_true = n_flag ^ v_flag;
            4'd8:  cond_true = ~z_flag & ~(n_flag ^ v_flag);
            4'd9:  cond_true = z_flag | (n_flag ^ v_flag);
            4'd10: cond_true = ~(n_flag ^ v_flag);
            4'd11: cond_true = n_flag;
            4'd12: cond_true = ~n_flag;
            4'd13: cond_true = v_flag;
            4'd14: cond_true = ~v_flag;
            default: cond_true = 1'b0;
        endcase
    end

    assign flags     = flags_reg;
    assign carry     = flags_reg[1];
    assign stack_err = err_reg;
    assign data_out  = oe ? {28'b0, flags_reg} : 32'bz;

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: directed literal checks plus randomized traffic compared
// every negedge against a queue-based model of flags, save stack and error bit.
`timescale 1ns/1ps
module tb_status_reg;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_status;
    logic        load;
    logic        we;
    logic [31:0] data_in;
    logic        oe;
    logic [31:0] data_out;
    logic        push;
    logic        pop;
    logic [3:0]  cond;
    logic        cond_true;
    logic        carry;
    logic        stack_err;
    logic [3:0]  flags;

    status_reg #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_status (alu_status),
        .load       (load),
        .we         (we),
        .data_in    (data_in),
        .oe         (oe),
        .data_out   (data_out),
        .push       (push),
        .pop        (pop),
        .cond       (cond),
        .cond_true  (cond_true),
        .carry      (carry),
        .stack_err  (stack_err),
        .flags      (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [3:0] m_flags = 4'b0000;
    logic       m_err   = 1'b0;
    logic [3:0] m_stack[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Condition meaning in terms of the flags: signed "less" is N!=V, unsigned "less" is a borrow.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, slt, ult;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        slt = (n != v);
        ult = !cy;
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return ult;
            4'd4:  return !ult && !z;
            4'd5:  return ult || z;
            4'd6:  return !ult;
            4'd7:  return slt;
            4'd8:  return !slt && !z;
            4'd9:  return slt || z;
            4'd10: return !slt;
            4'd11: return n;
            4'd12: return !n;
            4'd13: return v;
            4'd14: return !v;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: reacts to the same edges as the DUT using pre-edge inputs.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_flags = 4'b0000;
                m_err   = 1'b0;
                m_stack.delete();
            end else if (!(push && pop)) begin
                logic [3:0] old_flags;
                old_flags = m_flags;
                if (pop && m_stack.size() > 0) begin
                    m_flags = m_stack.pop_back();
                end else begin
                    if (pop) m_err = 1'b1;
                    if (we) m_flags = data_in[3:0];
                    else if (load) m_flags = alu_status;
                end
                if (push) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(old_flags);
                    else m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                chk("flags", {28'b0, flags}, {28'b0, m_flags});
                chk("carry", {31'b0, carry}, {31'b0, m_flags[1]});
                chk("stack_err", {31'b0, stack_err}, {31'b0, m_err});
                chk("cond_true", {31'b0, cond_true}, {31'b0, cond_eval(cond, m_flags)});
                if (oe) chk("data_out", data_out, {28'b0, m_flags});
            end
        end
    end

    task automatic cyc(input logic ld, input logic w, input logic [31:0] d,
                       input logic ps, input logic pp, input logic [3:0] alu);
        @(negedge clk);
        #1;
        load = ld; we = w; data_in = d; push = ps; pop = pp; alu_status = alu;
        @(posedge clk);
        #1;
        load = 1'b0; we = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic chk_cond(input logic [3:0] c, input logic exp);
        cond = c;
        #1;
        chk($sformatf("cond%0d", c), {31'b0, cond_true}, {31'b0, exp});
    endtask

    initial begin
        rst_n = 1'b0; oe = 1'b1; load = 1'b0; we = 1'b0; push = 1'b0; pop = 1'b0;
        data_in = 32'h0; alu_status = 4'h0; cond = 4'd0;
        #3;
        chk("data_out_in_reset", data_out, 32'h0);
        chk("flags_in_reset", {28'b0, flags}, 32'h0);
        #9;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_carry", {31'b0, carry}, 32'h0);
        chk("reset_err", {31'b0, stack_err}, 32'h0);
        chk_cond(4'd0, 1'b1);
        chk_cond(4'd15, 1'b0);

        // SUB 1-1: zero, no borrow
        cyc(1, 0, 0, 0, 0, 4'b0110);
        chk("flags_0110", {28'b0, flags}, 32'h6);
        chk("carry_0110", {31'b0, carry}, 32'h1);
        chk_cond(4'd1, 1'b1);
        chk_cond(4'd6, 1'b1);
        chk_cond(4'd4, 1'b0);
        chk_cond(4'd9, 1'b1);
        chk_cond(4'd7, 1'b0);

        // SUB 2-3: negative, borrow
        cyc(1, 0, 0, 0, 0, 4'b1000);
        chk_cond(4'd3, 1'b1);
        chk_cond(4'd7, 1'b1);
        chk_cond(4'd2, 1'b1);
        // SUB 0x80000000-1: overflow to positive, so signed result is "less"
        cyc(1, 0, 0, 0, 0, 4'b0011);
        chk_cond(4'd13, 1'b1);
        chk_cond(4'd8, 1'b0);
        chk_cond(4'd7, 1'b1);

        // we beats load
        cyc(1, 1, 32'hFFFF_FFF5, 0, 0, 4'b1111);
        chk("we_wins", {28'b0, flags}, 32'h5);
        chk("bus_read", data_out, 32'h5);

        // stack save/restore
        cyc(0, 0, 0, 1, 0, 4'h0);
        cyc(1, 0, 0, 0, 0, 4'b1000);
        cyc(0, 0, 0, 1, 0, 4'h0);
        cyc(1, 0, 0, 0, 0, 4'b0010);
        chk("pre_pop", {28'b0, flags}, 32'h2);
        cyc(0, 0, 0, 0, 1, 4'h0);
        chk("pop1", {28'b0, flags}, 32'h8);
        cyc(0, 0, 0, 0, 1, 4'h0);
        chk("pop2", {28'b0, flags}, 32'h5);
        chk("err_before_underflow", {31'b0, stack_err}, 32'h0);
        cyc(0, 0, 0, 0, 1, 4'h0);
        chk("pop3_flags", {28'b0, flags}, 32'h5);
        chk("pop3_err", {31'b0, stack_err}, 32'h1);

        // fresh reset, then push+pop no-op on an empty stack
        @(negedge clk); #1; rst_n = 1'b0; #2; rst_n = 1'b1;
        chk("rst_clears_err", {31'b0, stack_err}, 32'h0);
        cyc(1, 0, 0, 1, 1, 4'b1111);
        chk("pushpop_flags", {28'b0, flags}, 32'h0);
        chk("pushpop_err", {31'b0, stack_err}, 32'h0);

        // fill to DEPTH, then overflow
        for (int k = 1; k <= DEPTH; k++) cyc(1, 0, 0, 1, 0, 4'(k));
        chk("full_no_err", {31'b0, stack_err}, 32'h0);
        cyc(1, 0, 0, 1, 0, 4'd5);
        chk("overflow_err", {31'b0, stack_err}, 32'h1);
        chk("overflow_load", {28'b0, flags}, 32'h5);
        cyc(0, 0, 0, 0, 1, 4'h0);
        chk("pop_after_full", {28'b0, flags}, 32'h3);

        // reset in the middle of a push request
        @(negedge clk); #1;
        push = 1'b1;
        #1; rst_n = 1'b0;
        #1;
        chk("midrst_flags", {28'b0, flags}, 32'h0);
        chk("midrst_err", {31'b0, stack_err}, 32'h0);
        chk("midrst_bus", data_out, 32'h0);
        #1; rst_n = 1'b1; push = 1'b0;
        cyc(0, 0, 0, 0, 1, 4'h0);
        chk("pop_empty_after_rst", {31'b0, stack_err}, 32'h1);
        chk("pop_empty_flags", {28'b0, flags}, 32'h0);

        // randomized traffic checked by the negedge compare process
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); #1;
            load       = ($urandom_range(0, 2) == 0);
            we         = ($urandom_range(0, 4) == 0);
            push       = ($urandom_range(0, 2) == 0);
            pop        = ($urandom_range(0, 2) == 0);
            oe         = ($urandom_range(0, 1) == 0);
            data_in    = $urandom;
            alu_status = 4'($urandom_range(0, 15));
            cond       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
        end
        @(negedge clk); #1;
        load = 1'b0; we = 1'b0; push = 1'b0; pop = 1'b0;
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
